// File: rtl/gpr_wb.sv
// Writeback stage with register-file write port and issue scoreboard.
// Two producer channels (EXU ALU results, LSU load results) share one
// register-file write port. The LSU channel has fixed priority.
// The accepted result is held in a single pipeline register and drives
// the write port for exactly one cycle.
// A busy-bit scoreboard tracks destinations that were issued but are not
// yet written back. It answers two hazard queries and a pending count.
module gpr_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // ALU result channel
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  // load result channel
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  // register-file write port
  output logic [DATA_WIDTH-1:0] gpr_w,
  output logic [ADDR_WIDTH-1:0] gpr_w_addr,
  output logic                  gpr_w_en,
  // scoreboard set at issue
  input  logic                  sb_set_en,
  input  logic [ADDR_WIDTH-1:0] sb_set_addr,
  // hazard query
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic [ADDR_WIDTH:0]   pending_cnt
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic                  lsu_fire;
  logic                  exu_fire;

  logic                  wb_valid_reg;
  logic                  wb_valid_next;
  logic [DATA_WIDTH-1:0] wb_data_reg;
  logic [DATA_WIDTH-1:0] wb_data_next;
  logic [ADDR_WIDTH-1:0] wb_addr_reg;
  logic [ADDR_WIDTH-1:0] wb_addr_next;

  logic [NUM_REGS-1:0]   sb_bits;
  logic [ADDR_WIDTH:0]   pop_count;

  // Arbitration.
  // The LSU is always ready outside reset.
  // The EXU is stalled whenever the LSU presents a result.
  // Because of this, at most one channel can fire in any cycle.
  always_comb begin
    lsu_ready = !rst;
    exu_ready = !rst && !lsu_valid;
    lsu_fire  = lsu_valid && lsu_ready;
    exu_fire  = exu_valid && exu_ready;
  end

  // Next-state logic for the writeback register.
  // data/rd are captured only on a transfer; otherwise the previous values are held.
  // The valid flag lasts a single cycle, so every write is a one-cycle pulse.
  always_comb begin
    wb_valid_next = lsu_fire || exu_fire;
    wb_data_next  = wb_data_reg;
    wb_addr_next  = wb_addr_reg;
    if (lsu_fire) begin
      wb_data_next = lsu_data;
      wb_addr_next = lsu_rd;
    end else if (exu_fire) begin
      wb_data_next = exu_data;
      wb_addr_next = exu_rd;
    end
  end

  // Writeback register.
  // Reset drops any in-flight write and zeroes the visible port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
      wb_addr_reg  <= '0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      wb_data_reg  <= wb_data_next;
      wb_addr_reg  <= wb_addr_next;
    end
  end

  // Write port outputs.
  // A write to x0 is suppressed, but the data and address stay visible.
  always_comb begin
    gpr_w      = wb_data_reg;
    gpr_w_addr = wb_addr_reg;
    gpr_w_en   = wb_valid_reg && (wb_addr_reg != '0);
  end

  // One busy bit per architectural register.
  // x0 can never be pending, so its bit is tied low.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign sb_bits[gi] = 1'b0;
      end else begin : g_bit
        logic busy_reg;
        logic set_hit;
        logic clr_hit;

        // Decode this register's set (issue) and clear (writeback) requests.
        always_comb begin
          set_hit = sb_set_en && (sb_set_addr == ADDR_WIDTH'(gi));
          clr_hit = gpr_w_en && (gpr_w_addr == ADDR_WIDTH'(gi));
        end

        // The set request is checked first.
        // A new issue therefore overrides a retiring write to the same register.
        always_ff @(posedge clk) begin
          if (rst) begin
            busy_reg <= 1'b0;
          end else if (set_hit) begin
            busy_reg <= 1'b1;
          end else if (clr_hit) begin
            busy_reg <= 1'b0;
          end
        end

        assign sb_bits[gi] = busy_reg;
      end
    end
  endgenerate

  // Hazard query reads the registered scoreboard directly.
  // A set or clear in the same cycle does not change the answer until the next edge.
  always_comb begin
    rs1_busy = sb_bits[rs1_addr];
    rs2_busy = sb_bits[rs2_addr];
  end

  // Population count of the registered scoreboard.
  // The result is at most NUM_REGS-1, so it cannot wrap.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pop_count = pop_count + (ADDR_WIDTH + 1)'(sb_bits[i]);
    end
  end

  assign pending_cnt = pop_count;

endmodule

// File: tb/tb_gpr_wb.sv
// Self-checking bench for gpr_wb.
// Inputs are driven just after the falling edge, and outputs are compared
// 1 ns later against a behavioural model. The model is advanced at each
// rising edge. Directed scenarios come first, then randomized traffic.
module tb_gpr_wb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk;
  logic          rst;
  logic          exu_valid;
  logic          exu_ready;
  logic [DW-1:0] exu_data;
  logic [AW-1:0] exu_rd;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [DW-1:0] lsu_data;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] gpr_w;
  logic [AW-1:0] gpr_w_addr;
  logic          gpr_w_en;
  logic          sb_set_en;
  logic [AW-1:0] sb_set_addr;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic          rs1_busy;
  logic          rs2_busy;
  logic [AW:0]   pending_cnt;

  gpr_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_data    (exu_data),
    .exu_rd      (exu_rd),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_data    (lsu_data),
    .lsu_rd      (lsu_rd),
    .gpr_w       (gpr_w),
    .gpr_w_addr  (gpr_w_addr),
    .gpr_w_en    (gpr_w_en),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  // m_busy holds the registers that are pending.
  // The m_wb_* variables hold the result that will be presented on the write port.
  bit          m_busy [NR];
  bit          m_wb_valid;
  bit [AW-1:0] m_wb_addr;
  bit [DW-1:0] m_wb_data;

  int n_checks;
  int n_pass;
  int cyc_n;
  bit check_en;

  // Count one comparison and report it when the observed value differs from the expected one.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc_n, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Return the number of registers the model marks as pending.
  function automatic int model_pending();
    int c = 0;
    for (int i = 0; i < NR; i++) begin
      c += int'(m_busy[i]);
    end
    return c;
  endfunction

  // One clock cycle.
  // Check the outputs for the inputs currently applied, then let the edge occur and advance the model.
  task automatic cyc();
    bit exp_en;
    #1;
    exp_en = m_wb_valid && (m_wb_addr != 0);
    if (check_en) begin
      check("lsu_ready", 64'(lsu_ready), 64'(!rst));
      check("exu_ready", 64'(exu_ready), 64'(!rst && !lsu_valid));
      check("gpr_w_en", 64'(gpr_w_en), 64'(exp_en));
      check("gpr_w_addr", 64'(gpr_w_addr), 64'(m_wb_addr));
      check("gpr_w", 64'(gpr_w), 64'(m_wb_data));
      check("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
      check("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
      check("pending_cnt", 64'(pending_cnt), 64'(model_pending()));
      if (exp_en) begin
        $display("cycle %0d: writeback x%0d <= 0x%08h", cyc_n, m_wb_addr, m_wb_data);
      end
    end
    @(posedge clk);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_wb_valid = 1'b0;
      m_wb_addr  = '0;
      m_wb_data  = '0;
    end else begin
      // A retiring write frees its register.
      if (exp_en) m_busy[m_wb_addr] = 1'b0;
      // A new issue then marks its destination, so it wins over a clear in the same cycle.
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
      if (lsu_valid) begin
        m_wb_valid = 1'b1;
        m_wb_addr  = lsu_rd;
        m_wb_data  = lsu_data;
      end else if (exu_valid) begin
        m_wb_valid = 1'b1;
        m_wb_addr  = exu_rd;
        m_wb_data  = exu_data;
      end else begin
        m_wb_valid = 1'b0;
      end
    end
    @(negedge clk);
    cyc_n++;
  endtask

  // Return every input to its quiet value; reset is left unchanged.
  task automatic idle();
    exu_valid   = 1'b0;
    exu_data    = '0;
    exu_rd      = '0;
    lsu_valid   = 1'b0;
    lsu_data    = '0;
    lsu_rd      = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
    rs1_addr    = '0;
    rs2_addr    = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc_n    = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    idle();
    @(negedge clk);

    // Reset: the first cycle is unchecked; after it every output must read zero.
    cyc();
    check_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // A single EXU write appears one cycle after acceptance and lasts one cycle.
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h0000_1234;
    cyc();
    idle();
    cyc();
    cyc();

    // Both channels valid: the LSU wins, and the EXU is accepted in the following cycle.
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAAAA_0003;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBBBB_0004;
    cyc();
    lsu_valid = 1'b0;
    cyc();
    idle();
    cyc();
    cyc();

    // Scoreboard set, busy query, then clear after the LSU write.
    sb_set_en = 1'b1; sb_set_addr = 5'd7;
    cyc();
    idle(); rs1_addr = 5'd7;
    cyc();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_7777;
    cyc();
    lsu_valid = 1'b0;
    cyc();
    cyc();

    // A set in the same cycle as the write of the same register: the set wins.
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd9;
    cyc();
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999_0009;
    cyc();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd9; rs2_addr = 5'd9;
    cyc();
    idle(); rs2_addr = 5'd9;
    cyc();

    // Writes to x0 and sets of x0 have no effect.
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hFFFF_FFFF;
    cyc();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd0;
    cyc();
    idle();
    cyc();

    // Reset right after an accept drops the write and ignores all inputs.
    exu_valid = 1'b1; exu_rd = 5'd6; exu_data = 32'h6666_6666;
    cyc();
    rst = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd10; sb_set_en = 1'b1; sb_set_addr = 5'd8;
    cyc();
    rst = 1'b0; idle(); rs1_addr = 5'd8;
    cyc();
    cyc();

    // Randomized traffic.
    // Addresses are biased toward a small range so that hazards and collisions occur often.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      exu_valid   = ($urandom_range(0, 1) == 1);
      exu_data    = $urandom;
      exu_rd      = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      lsu_valid   = ($urandom_range(0, 9) < 3);
      lsu_data    = $urandom;
      lsu_rd      = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      sb_set_en   = ($urandom_range(0, 9) < 4);
      sb_set_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rs1_addr    = AW'($urandom_range(0, 9));
      rs2_addr    = AW'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpr_wb.md
GPR_WB -- requirements
Module: ysyx_23060075_gpr_wb

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, GPR data width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 5, GPR index width (2^ADDR_WIDTH registers).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports exu_valid  input  1 / exu_ready  output  1 / exu_data  input  DATA_WIDTH / exu_rd  input  ADDR_WIDTH  ALU result channel.
REQ-007 SHALL have ports lsu_valid  input  1 / lsu_ready  output  1 / lsu_data  input  DATA_WIDTH / lsu_rd  input  ADDR_WIDTH  load result channel.
REQ-008 SHALL have ports gpr_w  output  DATA_WIDTH / gpr_w_addr  output  ADDR_WIDTH / gpr_w_en  output  1  register-file write port.
REQ-009 SHALL have ports sb_set_en  input  1 / sb_set_addr  input  ADDR_WIDTH  mark destination pending at issue.
REQ-010 SHALL have ports rs1_addr, rs2_addr  input  ADDR_WIDTH / rs1_busy, rs2_busy  output  1  hazard query.
REQ-011 SHALL have port pending_cnt  output  ADDR_WIDTH+1  number of set scoreboard bits.

Function
REQ-012 Handshake: transfer on a channel SHALL occur when valid && ready at a rising edge; data/rd SHALL be sampled only then.
REQ-013 Arbitration: lsu_ready SHALL be 1 whenever not in reset; exu_ready SHALL be !lsu_valid (LSU fixed priority); at most one transfer per cycle.
REQ-014 Writeback stage: an accepted transfer at edge N SHALL drive gpr_w_en=1, gpr_w, gpr_w_addr from registers during cycle N+1 only (latency 1, one-cycle pulse); no accept at N -> gpr_w_en=0 in N+1.
REQ-015 gpr_w_en SHALL be 0 when the registered rd is 0 (x0 writes suppressed); gpr_w/gpr_w_addr still show registered values.
REQ-016 Back-to-back accepts on consecutive edges SHALL produce gpr_w_en high on consecutive cycles with no bubble.
REQ-017 Scoreboard: one busy bit per register; bit 0 SHALL be constant 0; sb_set_en with sb_set_addr != 0 SHALL set the bit at that edge.
REQ-018 The bit for gpr_w_addr SHALL clear at the edge ending a cycle with gpr_w_en=1.
REQ-019 Set and clear of the same address at the same edge: set SHALL win (bit stays 1).
REQ-020 Set of an already-set bit SHALL leave it 1; clear of an unset bit SHALL leave it 0; no error signalled.
REQ-021 rsN_busy SHALL be combinational read of the current scoreboard bit (no bypass of same-cycle set/clear); rsN_addr=0 -> 0.
REQ-022 pending_cnt SHALL equal the population count of the registered scoreboard, range 0..2^ADDR_WIDTH-1, no wrap.

Reset
REQ-023 While rst=1 at an edge: scoreboard cleared, writeback stage invalidated; following cycle gpr_w_en=0, gpr_w=0, gpr_w_addr=0, pending_cnt=0, rs1_busy=rs2_busy=0.
REQ-024 While rst=1, exu_ready=lsu_ready=0; transfers and sb_set_en SHALL be ignored; an in-flight write SHALL be dropped.

Verification
REQ-025 Reset, then exu_valid=1, exu_rd=5, exu_data=0x1234 one cycle -> next cycle gpr_w_en=1, gpr_w_addr=5, gpr_w=0x1234; then gpr_w_en=0.
REQ-026 exu_valid=lsu_valid=1 (rd 3 / rd 4) same cycle -> exu_ready=0, LSU write rd 4 next cycle; EXU held, accepted cycle after, write rd 3 following cycle.
REQ-027 sb_set_en addr 7; rs1_addr=7 -> rs1_busy=1, pending_cnt=1; LSU writes rd 7 -> after write cycle rs1_busy=0, pending_cnt=0.
REQ-028 Write cycle for rd 9 coincides with sb_set_en addr 9 -> bit 9 remains 1, pending_cnt unchanged.
REQ-029 exu_rd=0, data 0xFFFF_FFFF accepted -> gpr_w_en stays 0; sb_set_en addr 0 -> pending_cnt stays 0.
REQ-030 rst asserted in cycle after an accept -> gpr_w_en=0 following cycle, scoreboard all 0, ready signals 0 during rst.
